// File: rtl/parser_arb_pkg.sv
// rtl/parser_arb_pkg.sv - shared types and helpers for the parser input arbiter
package parser_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    FLUSH = 2'd2
  } arb_state_e;

  localparam int DATA_W_DEF = 32;

  // Source-id width; a single-source build still needs one bit.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/parser_input_arbiter_if.sv
// rtl/parser_input_arbiter_if.sv - source feeds, parser-side beat stream and status
interface parser_input_arbiter_if #(
  parameter int N_SRC  = 4,
  parameter int DATA_W = 32
);
  localparam int IDW = parser_arb_pkg::id_w(N_SRC);

  logic [N_SRC-1:0]        src_en;
  logic [N_SRC*DATA_W-1:0] src_data;
  logic [N_SRC-1:0]        src_val;
  logic [N_SRC-1:0]        src_last;
  logic [N_SRC-1:0]        src_ready;
  logic [DATA_W-1:0]       dataOut;
  logic                    dataOut_val;
  logic                    dataOut_last;
  logic                    dataOut_ready;
  logic [IDW-1:0]          grant_id;
  logic                    busy;
  logic                    abort;
  logic [IDW-1:0]          abort_id;

  // master: the arbiter itself; slave: the environment around it.
  modport master (
    input  src_en, src_data, src_val, src_last, dataOut_ready,
    output src_ready, dataOut, dataOut_val, dataOut_last,
    output grant_id, busy, abort, abort_id
  );

  modport slave (
    output src_en, src_data, src_val, src_last, dataOut_ready,
    input  src_ready, dataOut, dataOut_val, dataOut_last,
    input  grant_id, busy, abort, abort_id
  );

endinterface

// File: rtl/parser_input_arbiter_rr_pick.sv
// rtl/parser_input_arbiter_rr_pick.sv - combinational round-robin picker
// Returns the first requester at or after ptr_i, wrapping from N_SRC-1 to 0.
module rr_pick
  import parser_arb_pkg::*;
#(
  parameter  int N_SRC = 4,
  localparam int IDW   = id_w(N_SRC)
) (
  input  logic [N_SRC-1:0] req_i,
  input  logic [IDW-1:0]   ptr_i,
  output logic [IDW-1:0]   gnt_id_o,
  output logic             gnt_any_o
);

  int idx;

  // Walk the offsets backwards so the smallest offset from ptr_i wins.
  always_comb begin
    gnt_id_o  = '0;
    gnt_any_o = 1'b0;
    idx       = 0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      idx = (int'(ptr_i) + k) % N_SRC;
      if (req_i[idx]) begin
        gnt_id_o  = IDW'(idx);
        gnt_any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/parser_input_arbiter.sv
// rtl/parser_input_arbiter.sv - packet-level round-robin arbiter in front of the parser
// Holds a grant for a whole packet; a source stalled mid-packet is cut off with a zero last beat.
module parser_input_arbiter
  import parser_arb_pkg::*;
#(
  parameter int N_SRC   = 4,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   reset_b,
  parser_input_arbiter_if.master bus
);

  localparam int IDW  = id_w(N_SRC);
  localparam int CNTW = $clog2(TIMEOUT);

  arb_state_e        state_q;
  logic [IDW-1:0]    ptr_q;
  logic [IDW-1:0]    grant_q;
  logic [IDW-1:0]    abort_id_q;
  logic              abort_q;
  logic [N_SRC-1:0]  drain_q;
  logic [N_SRC-1:0]  drain_d;
  logic [CNTW-1:0]   cnt_q;

  logic [N_SRC-1:0]  elig;
  logic [IDW-1:0]    win_id;
  logic              win_any;

  logic [N_SRC-1:0]  ready_mux;
  logic [DATA_W-1:0] data_mux;
  logic              val_mux;
  logic              last_mux;

  assign elig = bus.src_val & bus.src_en & ~drain_q;

  rr_pick #(.N_SRC(N_SRC)) u_rr_pick (
    .req_i     (elig),
    .ptr_i     (ptr_q),
    .gnt_id_o  (win_id),
    .gnt_any_o (win_any)
  );

  // A draining source drops its flag once its own last beat has been swallowed.
  assign drain_d = drain_q & ~(bus.src_val & bus.src_last);

  always_comb begin
    ready_mux = drain_q;
    data_mux  = '0;
    val_mux   = 1'b0;
    last_mux  = 1'b0;
    case (state_q)
      GRANT: begin
        data_mux           = bus.src_data[grant_q*DATA_W +: DATA_W];
        val_mux            = bus.src_val[grant_q];
        last_mux           = bus.src_last[grant_q];
        ready_mux[grant_q] = bus.dataOut_ready;
      end
      FLUSH: begin
        val_mux  = 1'b1;
        last_mux = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      grant_q    <= '0;
      abort_q    <= 1'b0;
      abort_id_q <= '0;
      drain_q    <= '0;
      cnt_q      <= '0;
    end else begin
      abort_q <= 1'b0;
      drain_q <= drain_d;
      case (state_q)
        IDLE: begin
          if (win_any) begin
            grant_q <= win_id;
            ptr_q   <= (win_id == IDW'(N_SRC - 1)) ? '0 : win_id + 1'b1;
            cnt_q   <= '0;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          // Any presented beat (even backpressured) proves the source is alive.
          if (bus.src_val[grant_q]) begin
            cnt_q <= '0;
            if (bus.dataOut_ready && bus.src_last[grant_q]) begin
              state_q <= IDLE;
            end
          end else if (cnt_q == CNTW'(TIMEOUT - 1)) begin
            cnt_q            <= '0;
            drain_q[grant_q] <= 1'b1;
            state_q          <= FLUSH;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        FLUSH: begin
          if (bus.dataOut_ready) begin
            abort_q    <= 1'b1;
            abort_id_q <= grant_q;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.src_ready    = ready_mux;
  assign bus.dataOut      = data_mux;
  assign bus.dataOut_val  = val_mux;
  assign bus.dataOut_last = last_mux;
  assign bus.grant_id     = grant_q;
  assign bus.busy         = (state_q != IDLE);
  assign bus.abort        = abort_q;
  assign bus.abort_id     = abort_id_q;

endmodule
